// File: rtl/gate_vec_decoder.sv
// Decodes a 6-bit gate-result vector {and,nand,or,nor,xor,xnor} back to the number of ones
// in the source operand pair, behind a one-entry valid/ready pipeline stage.
module gate_vec_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_ones,
    output logic             out_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e     state_q;
    logic       accept;
    logic [1:0] dec_ones;
    logic       dec_err;

    // rst_n gates in_ready so nothing is taken while reset is held.
    assign in_ready  = rst_n & ((state_q == StEmpty) | out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == StFull);

    always_comb begin
        dec_ones = 2'd0;
        dec_err  = 1'b0;
        unique case (in_z)
            6'h15:   dec_ones = 2'd0;
            6'h1A:   dec_ones = 2'd1;
            6'h29:   dec_ones = 2'd2;
            default: dec_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            out_ones <= 2'd0;
            out_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) state_q <= StFull;
                end
                StFull: begin
                    if (out_ready && !in_valid) state_q <= StEmpty;
                end
                default: state_q <= StEmpty;
            endcase

            if (accept) begin
                out_ones <= dec_ones;
                out_err  <= dec_err;
            end

            // Counted at acceptance; clear wins over a simultaneous increment.
            if (clr_cnt) begin
                err_cnt <= '0;
            end else if (accept && dec_err && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule
